// File: rtl/spiker_adapter_pkg.sv
// spiker_adapter_pkg: shared spiker adapter defaults and reader FSM state type
package spiker_adapter_pkg;
  localparam int SPIKER_WIDTH = 32;
  localparam int SPIKER_N_SPIKES = 784;
  localparam int SPIKER_N_REG = 25;
  typedef enum logic [1:0] {IDLE, LOAD, OFFER} spiker_state_e;
endpackage

// File: rtl/spiker_adapter_reg_pkg.sv
// spiker_adapter_reg_pkg: register file to hardware view of the spike input registers
package spiker_adapter_reg_pkg;
  typedef struct packed {
    logic [spiker_adapter_pkg::SPIKER_WIDTH-1:0] q;
  } spiker_adapter_reg2hw_spikes_input_mreg_t;
  typedef struct packed {
    spiker_adapter_reg2hw_spikes_input_mreg_t [spiker_adapter_pkg::SPIKER_N_REG-1:0] spikes_input;
  } spiker_adapter_reg2hw_t;
endpackage

// File: rtl/spiker_reader.sv
// spiker_reader: copies N_REG spike words into one vector and offers it to the spiker; SPIKER_READER_PAD_MASK_EN zeroes the pad bits above N_SPIKES
module spiker_reader
  import spiker_adapter_pkg::*;
  import spiker_adapter_reg_pkg::*;
#(
  parameter int WIDTH = SPIKER_WIDTH,
  parameter int N_SPIKES = SPIKER_N_SPIKES,
  parameter int N_REG = SPIKER_N_REG,
  parameter int DATA_WIDTH = 800
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   test_mode_i,
  input  spiker_adapter_reg2hw_t reg_file_to_ip,
  input  logic                   start_i,
  output logic [DATA_WIDTH-1:0]  data_in_o,
  output logic                   data_valid_o,
  input  logic                   spiker_ready_i,
  output logic                   busy_o,
  output logic                   done_o
);
  localparam int CW = N_REG > 1 ? $clog2(N_REG) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_REG - 1);
  if (DATA_WIDTH != N_REG * WIDTH || N_SPIKES > DATA_WIDTH) begin : g_bad_cfg
    $error("spiker_reader: DATA_WIDTH must equal N_REG*WIDTH and N_SPIKES must not exceed DATA_WIDTH");
  end
  if (WIDTH != SPIKER_WIDTH || N_REG > SPIKER_N_REG) begin : g_bad_reg
    $error("spiker_reader: WIDTH/N_REG do not fit the register file view");
  end
  spiker_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d, done_q, done_d, fire, unused_test_mode;
  assign unused_test_mode = test_mode_i;
  assign fire = state_q == OFFER && valid_q && spiker_ready_i;
  always_comb begin
    state_d = state_q == IDLE ? (start_i ? LOAD : IDLE) :
              state_q == LOAD ? (cnt_q == LAST ? OFFER : LOAD) :
              (fire ? IDLE : OFFER);
    cnt_d = state_q != LOAD ? '0 : cnt_q == LAST ? cnt_q : cnt_q + 1'b1;
    valid_d = state_q == OFFER && !fire;
    done_d = fire;
    data_d = data_q;
    if (state_q == LOAD) data_d[cnt_q*WIDTH +: WIDTH] = reg_file_to_ip.spikes_input[cnt_q].q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      valid_q <= valid_d;
      done_q <= done_d;
    end
  end
`ifdef SPIKER_READER_PAD_MASK_EN
  localparam logic [DATA_WIDTH-1:0] PAD_MASK = ~({DATA_WIDTH{1'b1}} << N_SPIKES);
  assign data_in_o = data_q & PAD_MASK;
`else
  assign data_in_o = data_q;
`endif
  assign data_valid_o = valid_q;
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
endmodule
